// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall controller: hazard sources in, stage controls out.
// HAZARD_PERF_CNT_EN adds the two performance counter outputs.
interface hazard_stall_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_stall;
    logic       id_ex_flush;
    logic       ex_mem_stall;
    logic       mem_wb_flush;
    logic       mem_timeout;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_cycles;
    logic [CNT_W-1:0] perf_flush_events;
`endif

    // Pipeline side: reports hazard sources, consumes stage controls.
    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_mem_read, ex_rd, ex_redirect, mem_req, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        input  ex_mem_stall, mem_wb_flush, mem_timeout, state_o
`ifdef HAZARD_PERF_CNT_EN
        , input perf_stall_cycles, perf_flush_events
`endif
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_mem_read, ex_rd, ex_redirect, mem_req, mem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        output ex_mem_stall, mem_wb_flush, mem_timeout, state_o
`ifdef HAZARD_PERF_CNT_EN
        , output perf_stall_cycles, perf_flush_events
`endif
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline with a data-memory wait/timeout FSM.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 16,  // legal range 2..255
    parameter int CNT_W   = 32
) (
    input logic              clk,
    input logic              rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t     state_p0;
    state_t     state_nx;
    logic [7:0] wait_cnt_p0;
    logic [7:0] wait_cnt_nx;

    logic mw;
    logic load_use;
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
    logic mem_timeout;
    logic [1:0] state_o;

    assign mw = bus.mem_req & ~bus.mem_ready;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0    <= RUN;
            wait_cnt_p0 <= 8'd0;
        end else begin
            state_p0    <= state_nx;
            wait_cnt_p0 <= wait_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = RUN;
        wait_cnt_nx  = 8'd0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        mem_timeout  = 1'b0;
        state_o      = 2'd0;

        if (!rst) begin
            state_o = state_p0;
            case (state_p0)
                RUN, MEM_WAIT: begin
                    if (mw) begin
                        // Freeze everything up to MEM and bubble WB; redirect/load-use wait.
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                        mem_wb_flush = 1'b1;
                        if (state_p0 == RUN) begin
                            state_nx    = MEM_WAIT;
                            wait_cnt_nx = 8'd1;
                        end else begin
                            state_nx    = (wait_cnt_p0 == WAIT_LAST) ? ABORT : MEM_WAIT;
                            wait_cnt_nx = wait_cnt_p0 + 8'd1;
                        end
                    end else if (bus.ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                ABORT: begin
                    // Let the pipeline advance once with the stuck access dropped.
                    mem_timeout  = 1'b1;
                    mem_wb_flush = 1'b1;
                end
                default: begin
                    state_nx = RUN;
                end
            endcase
        end
    end

    assign bus.pc_stall     = pc_stall;
    assign bus.if_id_stall  = if_id_stall;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_stall  = id_ex_stall;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_stall = ex_mem_stall;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.mem_timeout  = mem_timeout;
    assign bus.state_o      = state_o;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_p0;
    logic [CNT_W-1:0] flush_events_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_p0 <= '0;
            flush_events_p0 <= '0;
        end else begin
            if (pc_stall)
                stall_cycles_p0 <= sat_inc(stall_cycles_p0);
            if (if_id_flush || mem_timeout)
                flush_events_p0 <= sat_inc(flush_events_p0);
        end
    end

    assign bus.perf_stall_cycles = stall_cycles_p0;
    assign bus.perf_flush_events = flush_events_p0;
`else
    // Counters are absent in this build; the port list carries no perf signals.
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (TIMEOUT=4); outputs checked #1 after each falling edge.
module tb_hazard_stall_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    // Output vector order: pc_stall if_id_stall if_id_flush id_ex_stall id_ex_flush ex_mem_stall mem_wb_flush mem_timeout
    localparam logic [7:0] O_NONE = 8'h00;
    localparam logic [7:0] O_FRZ  = 8'hD6;
    localparam logic [7:0] O_LU   = 8'hC8;
    localparam logic [7:0] O_RED  = 8'h28;
    localparam logic [7:0] O_ABT  = 8'h03;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    bit          perf_ok = 1'b0;
`endif

    task automatic idle();
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_rs1_used = 1'b0;
        bus.id_rs2_used = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.ex_redirect = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_ready   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp_o, input logic [1:0] exp_s);
        logic [7:0] got;
        got = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
               bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_flush, bus.mem_timeout};
        n_cmp++;
        assert (got === exp_o) else begin
            n_fail++;
            $error("FAIL %s outputs: observed %b expected %b", tag, got, exp_o);
        end
        n_cmp++;
        assert (bus.state_o === exp_s) else begin
            n_fail++;
            $error("FAIL %s state: observed %0d expected %0d", tag, bus.state_o, exp_s);
        end
`ifdef HAZARD_PERF_CNT_EN
        if (perf_ok) begin
            n_cmp++;
            assert (bus.perf_stall_cycles === m_stall) else begin
                n_fail++;
                $error("FAIL %s perf_stall: observed %0d expected %0d", tag, bus.perf_stall_cycles, m_stall);
            end
            n_cmp++;
            assert (bus.perf_flush_events === m_flush) else begin
                n_fail++;
                $error("FAIL %s perf_flush: observed %0d expected %0d", tag, bus.perf_flush_events, m_flush);
            end
        end
        if (rst) begin
            m_stall = 32'd0;
            m_flush = 32'd0;
            perf_ok = 1'b1;
        end else begin
            if (exp_o[7]) m_stall = m_stall + 32'd1;
            if (exp_o[5] || exp_o[0]) m_flush = m_flush + 32'd1;
        end
`endif
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        idle();
        rst = 1'b1;

        // Reset with hazards present: everything must be quiet.
        @(negedge clk);
        bus.mem_req = 1'b1; bus.ex_redirect = 1'b1;
        #1 chk("reset", O_NONE, 2'd0);
        @(negedge clk);
        rst = 1'b0; idle();
        #1 chk("idle", O_NONE, 2'd0);

        // Load-use on rs2, then the load has left EX.
        @(negedge clk);
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_rs2_used = 1'b1;
        #1 chk("lu_rs2", O_LU, 2'd0);
        @(negedge clk);
        idle();
        #1 chk("lu_gone", O_NONE, 2'd0);
        @(negedge clk);
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_rs1_used = 1'b1;
        #1 chk("lu_rs1", O_LU, 2'd0);
        @(negedge clk);
        bus.id_rs1_used = 1'b0;
        #1 chk("lu_unused", O_NONE, 2'd0);
        @(negedge clk);
        idle(); bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0; bus.id_rs2_used = 1'b1;
        #1 chk("lu_x0", O_NONE, 2'd0);
        @(negedge clk);
        idle(); bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_rs1_used = 1'b1;
        #1 chk("no_load", O_NONE, 2'd0);

        // Redirect outranks load-use.
        @(negedge clk);
        idle(); bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5;
        bus.id_rs2_used = 1'b1; bus.ex_redirect = 1'b1;
        #1 chk("redir_lu", O_RED, 2'd0);

        // Three-cycle memory wait.
        @(negedge clk);
        idle(); bus.mem_req = 1'b1;
        #1 chk("mw3_c1", O_FRZ, 2'd0);
        @(negedge clk);
        #1 chk("mw3_c2", O_FRZ, 2'd1);
        @(negedge clk);
        #1 chk("mw3_c3", O_FRZ, 2'd1);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1 chk("mw3_ready", O_NONE, 2'd1);
        @(negedge clk);
        idle();
        #1 chk("mw3_done", O_NONE, 2'd0);

        // Redirect held through a freeze fires on the first unfrozen cycle.
        @(negedge clk);
        bus.mem_req = 1'b1; bus.ex_redirect = 1'b1;
        #1 chk("rf_c1", O_FRZ, 2'd0);
        @(negedge clk);
        #1 chk("rf_c2", O_FRZ, 2'd1);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1 chk("rf_ready", O_RED, 2'd1);
        @(negedge clk);
        idle();
        #1 chk("rf_done", O_NONE, 2'd0);

        // Timeout: four frozen cycles, one abort cycle (redirect and mem_req ignored), back to RUN.
        @(negedge clk);
        bus.mem_req = 1'b1;
        #1 chk("to_c1", O_FRZ, 2'd0);
        @(negedge clk);
        #1 chk("to_c2", O_FRZ, 2'd1);
        @(negedge clk);
        #1 chk("to_c3", O_FRZ, 2'd1);
        @(negedge clk);
        #1 chk("to_c4", O_FRZ, 2'd1);
        @(negedge clk);
        bus.ex_redirect = 1'b1;
        #1 chk("to_abort", O_ABT, 2'd2);
        @(negedge clk);
        idle();
        #1 chk("to_run", O_NONE, 2'd0);

        // Reset in the second MEM_WAIT cycle.
        @(negedge clk);
        bus.mem_req = 1'b1;
        #1 chk("rw_c1", O_FRZ, 2'd0);
        @(negedge clk);
        #1 chk("rw_c2", O_FRZ, 2'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rw_rst", O_NONE, 2'd0);
        @(negedge clk);
        rst = 1'b0; idle();
        #1 chk("rw_after", O_NONE, 2'd0);
        @(negedge clk);
        #1 chk("rw_idle", O_NONE, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline. It watches decode-stage register reads, the EX-stage load destination, the EX-stage control-flow redirect, and the data-memory handshake. It drives the per-stage freeze and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. A small FSM handles multi-cycle data-memory waits, including a timeout abort.

Parameters:
TIMEOUT, 16, max consecutive MEM-wait cycles before abort; legal range 2..255
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset
id_rs1  in  5  rs1 address of the instruction in ID
id_rs2  in  5  rs2 address of the instruction in ID
id_rs1_used  in  1  ID instruction actually reads rs1
id_rs2_used  in  1  ID instruction actually reads rs2
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of the instruction in EX
ex_redirect  in  1  EX resolved a taken branch, jal or jalr
mem_req  in  1  MEM stage holds a load/store access
mem_ready  in  1  data memory completes the access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  load NOP into IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  load NOP into ID/EX
ex_mem_stall  out  1  hold EX/MEM
mem_wb_flush  out  1  load NOP into MEM/WB
mem_timeout  out  1  one-cycle pulse on access abort
state_o  out  2  current FSM state, for debug

Behaviour:
- Reset rst is synchronous and active-high. While rst=1, all outputs are 0, the state is RUN and the wait counter is 0.
- States: RUN=0, MEM_WAIT=1, ABORT=2. Code 3 is illegal and maps to RUN on the next edge.
- All outputs are combinational from (state, inputs). The state and wait counter are registered. There is no added latency.
- The memory-wait condition is mw = mem_req & ~mem_ready, evaluated in RUN and MEM_WAIT.
- Wait freeze (mw=1):
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are all 1.
  - mem_wb_flush=1.
  - Every other output is 0; redirect and load-use are suppressed.
- RUN to MEM_WAIT on mw=1, with wait_cnt set to 1.
- MEM_WAIT with mw=1: wait_cnt increments. When wait_cnt == TIMEOUT-1 on that edge, the next state is ABORT.
- MEM_WAIT with mem_ready=1: no freeze this cycle; the next state is RUN and wait_cnt is cleared.
- ABORT (exactly one cycle):
  - mem_timeout=1 and mem_wb_flush=1.
  - mem_req and mem_ready are ignored.
  - The stall outputs are 0, so the pipeline advances and the access is dropped.
  - The next state is RUN.
- Redirect (no freeze, ex_redirect=1): if_id_flush=1 and id_ex_flush=1. PC is not stalled; it loads the target. The load-use check is ignored.
- Load-use (no freeze, no redirect): the hazard is ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1.
  - Lasts exactly one cycle, because the load leaves EX.
- Priority: ABORT > freeze > redirect > load-use > none.
- A redirect held in EX during a freeze takes effect on the first unfrozen cycle.
- Register x0 never causes a load-use hazard.
- A stall and a flush are never both asserted on the same register.
- Reset during MEM_WAIT or ABORT returns to RUN with no mem_timeout pulse.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: add outputs perf_stall_cycles [CNT_W] and perf_flush_events [CNT_W], both reset to 0.
  - perf_stall_cycles increments each cycle pc_stall=1.
  - perf_flush_events increments each cycle if_id_flush=1 or mem_timeout=1.
  - Both saturate at all-ones.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> for one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1, others 0. With ex_rd=0 -> all outputs 0.
- Redirect plus load-use in the same cycle: ex_redirect=1 and a load-use match -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Memory wait of 3 cycles: mem_req=1, mem_ready low 3 cycles then high -> 3 freeze cycles with mem_wb_flush=1; state 0->1->1->1->0; mem_timeout never asserts.
- Timeout with TIMEOUT=4: mem_req=1, mem_ready=0 held -> 4 freeze cycles, then one ABORT cycle (mem_timeout=1, mem_wb_flush=1, stalls=0), then state=0.
- Redirect during a freeze: ex_redirect=1 while mw=1 for 2 cycles -> no flush during those cycles; if_id_flush=1 on the cycle mem_ready=1.
- Reset mid-wait: rst=1 in the 2nd MEM_WAIT cycle -> all outputs 0 that cycle, state_o=0 next cycle, no mem_timeout. With HAZARD_PERF_CNT_EN defined, both counters read 0.
